// File: rtl/sram_reader.sv
// sram_reader: reads little-endian 32-bit words from a byte-wide async SRAM.
// Define SRAM_READER_STREAM_EN to let RESP chain straight into the next word.
module sram_reader #(
    parameter int WAIT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [20:0] req_addr,
    input  logic        stream,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [20:0] sram_addr,
    input  logic [7:0]  sram_data,
    output logic        sram_ce,
    output logic        sram_oe,
    output logic        sram_we,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, READ, RESP} state_t;
    state_t state, next;
    logic [1:0] idx;
    logic [3:0] wcnt;
    logic       sample, accept, restart, stream_go;
`ifdef SRAM_READER_STREAM_EN
    assign stream_go = stream;
`else
    assign stream_go = stream & 1'b0;
`endif
    assign accept  = state == IDLE && req_valid;
    assign sample  = state == READ && wcnt == 4'(WAIT);
    assign restart = state == RESP && rsp_ready && stream_go;
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= next;
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = req_valid ? READ : IDLE;
            READ:    next = (sample && idx == 2'd3) ? RESP : READ;
            RESP:    next = rsp_ready ? (stream_go ? READ : IDLE) : RESP;
            default: next = IDLE;
        endcase
    end
    // sram_addr doubles as base+idx; its low bits are the byte index while reading
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            sram_addr <= '0;
            rsp_data  <= '0;
            idx       <= '0;
            wcnt      <= '0;
        end else if (accept) begin
            sram_addr <= req_addr & 21'h1FFFFC;
            idx       <= '0;
            wcnt      <= '0;
        end else if (restart) begin
            sram_addr <= (sram_addr & 21'h1FFFFC) + 21'd4;
            idx       <= '0;
            wcnt      <= '0;
        end else if (sample) begin
            rsp_data[{idx, 3'b000} +: 8] <= sram_data;
            sram_addr <= idx == 2'd3 ? sram_addr : sram_addr + 21'd1;
            idx       <= idx + 2'd1;
            wcnt      <= '0;
        end else if (state == READ) begin
            wcnt      <= wcnt + 4'd1;
        end
    assign req_ready = state == IDLE;
    assign rsp_valid = state == RESP;
    assign busy      = state != IDLE;
    assign sram_ce   = state != READ;
    assign sram_oe   = state != READ;
    assign sram_we   = 1'b1;
endmodule

// File: doc/sram_reader.md
SRAM_READER -- requirements
Module: sram_reader

Interface
REQ-001 SHALL have parameter WAIT, default 2: extra wait cycles per byte access; legal range 0..15.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  word read request.
REQ-005 SHALL have port req_ready  output  1  block can accept a request.
REQ-006 SHALL have port req_addr  input  21  byte address; bits [1:0] ignored.
REQ-007 SHALL have port stream  input  1  continue to next word (see Configuration).
REQ-008 SHALL have port rsp_valid  output  1  rsp_data holds a complete word.
REQ-009 SHALL have port rsp_ready  input  1  consumer accepts the word.
REQ-010 SHALL have port rsp_data  output  32  assembled word, little-endian.
REQ-011 SHALL have port sram_addr  output  21  external SRAM byte address.
REQ-012 SHALL have port sram_data  input  8  external SRAM read data.
REQ-013 SHALL have ports sram_ce, sram_oe, sram_we  output  1 each  active-low SRAM strobes.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement exactly three states: IDLE, READ, RESP.
REQ-016 SHALL drive req_ready high only in IDLE, and SHALL accept a request on any edge where req_valid and req_ready are both high.
REQ-017 On acceptance, SHALL latch base = {req_addr[20:2], 2'b00}, clear byte index and wait counter, and enter READ.
REQ-018 In READ, SHALL drive sram_addr = base + byte index, sram_ce = 0, sram_oe = 0, sram_we = 1.
REQ-019 SHALL hold each byte address for WAIT+1 cycles, then sample sram_data on the final cycle into rsp_data[8*i+7:8*i], where i is the byte index.
REQ-020 After byte 3 is sampled, SHALL enter RESP and assert rsp_valid; with acceptance at edge T, rsp_valid SHALL first be high after edge T+4*(WAIT+1).
REQ-021 In RESP and IDLE, SHALL drive sram_ce = sram_oe = 1 and SHALL keep sram_addr at its last value.
REQ-022 SHALL hold rsp_valid and rsp_data stable until rsp_ready is high; on that edge SHALL return to IDLE (or restart per REQ-029).
REQ-023 SHALL ignore req_valid outside IDLE; a request held from RESP SHALL be accepted in the first IDLE cycle.
REQ-024 rsp_ready high while rsp_valid is low SHALL have no effect.
REQ-025 SHALL hold sram_we at 1 at all times; this block never writes.

Reset
REQ-026 While reset is high, SHALL asynchronously force IDLE; rsp_valid = 0; rsp_data = 0; sram_addr = 0; sram_ce = sram_oe = sram_we = 1; busy = 0.
REQ-027 Reset asserted mid-READ or mid-RESP SHALL abort the transfer and discard the partial word; no response SHALL appear after reset release.
REQ-028 SHALL drive req_ready high on the first cycle after reset release.

Configuration
REQ-029 With SRAM_READER_STREAM_EN defined: on the RESP edge where rsp_ready and stream are both high, SHALL set base to base+4 (1FFFFC wraps to 000000) and re-enter READ directly, without an IDLE cycle.
REQ-030 Without SRAM_READER_STREAM_EN defined, SHALL ignore stream; RESP SHALL always return to IDLE.

Verification
REQ-031 WAIT=2, request addr 21'h000103, SRAM model bytes 000100..000103 = 11,22,33,44 -> rsp_data = 32'h44332211; sram_addr sequence 100,101,102,103, each held 3 cycles; rsp_valid rises 12 cycles after acceptance.
REQ-032 WAIT=0, rsp_ready held low for 5 cycles after rsp_valid -> rsp_data stable; ce = oe = 1; req_ready = 0 throughout; IDLE on the rsp_ready edge.
REQ-033 Reset pulse during the byte-2 read -> strobes high immediately; no rsp_valid follows; the next request completes with correct data.
REQ-034 req_valid held high continuously -> back-to-back words, each separated by exactly one IDLE cycle; no request lost or duplicated.
REQ-035 STREAM_EN defined, base 1FFFFC, stream = 1, rsp_ready = 1 -> second word read from 000000..000003 with no IDLE cycle; STREAM_EN undefined -> single word only.
